// File: rtl/round_norm_pipe.sv
// round_norm_pipe: two-stage rounding and post-round normalisation for the FP multiplier.
// S1 takes the round decision and increments; S2 renormalises and saturates on overflow.
module round_norm_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sgn,
    input  logic [EXP_W:0]    in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_guard,
    input  logic              in_sticky,
    input  logic [2:0]        in_rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sgn,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_inexact,
    output logic              out_overflow
);
    typedef enum logic [2:0] {
        RND_NEAR    = 3'd0,
        RND_ZERO    = 3'd1,
        RND_PINF    = 3'd2,
        RND_NINF    = 3'd3,
        RND_NEAR_UP = 3'd4,
        RND_AWAY    = 3'd5,
        RND_RSVD6   = 3'd6,
        RND_RSVD7   = 3'd7
    } rnd_e;

    localparam logic [EXP_W+1:0] EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    logic              s1_ready, s2_ready, s1_load, s2_load;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

    logic              s1_sgn_q, s1_inexact_q;
    logic [EXP_W:0]    s1_exp_q;
    logic [MANT_W:0]   s1_sum_q, s1_sum_d;
    rnd_e              s1_rnd_q, s1_rnd_d;
    logic              s1_inexact_d, round_up;

    logic              out_sgn_q, out_inexact_q, out_overflow_q;
    logic              out_sgn_d, out_inexact_d, out_overflow_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [MANT_W-1:0] out_mant_q, out_mant_d;

    logic              carry, ovf, to_inf;
    logic [EXP_W+1:0]  exp_n;
    logic [MANT_W-1:0] mant_n;

    assign s2_ready   = !s2_valid_q || out_ready;
    assign s1_ready   = !s1_valid_q || s2_ready;
    assign in_ready   = s1_ready;
    assign s1_load    = in_valid && s1_ready;
    assign s2_load    = s1_valid_q && s2_ready;
    assign s1_valid_d = s1_ready ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;

    always_comb begin
        s1_rnd_d     = rnd_e'(in_rnd);
        s1_inexact_d = in_guard | in_sticky;
        round_up     = 1'b0;
        case (s1_rnd_d)
            RND_NEAR:    round_up = in_guard & (in_sticky | in_mant[0]);
            RND_PINF:    round_up = !in_sgn & s1_inexact_d;
            RND_NINF:    round_up = in_sgn & s1_inexact_d;
            RND_NEAR_UP: round_up = in_guard;
            RND_AWAY:    round_up = s1_inexact_d;
            default:     round_up = 1'b0;
        endcase
        s1_sum_d = {1'b0, in_mant} + {{MANT_W{1'b0}}, round_up};
    end

    // exp_n is two bits wider than the output so a carried pre-overflow can never wrap.
    always_comb begin
        carry  = s1_sum_q[MANT_W];
        mant_n = carry ? s1_sum_q[MANT_W:1] : s1_sum_q[MANT_W-1:0];
        exp_n  = {1'b0, s1_exp_q} + {{(EXP_W+1){1'b0}}, carry};
        ovf    = (exp_n >= EXP_OVF);
        to_inf = 1'b0;
        case (s1_rnd_q)
            RND_NEAR, RND_NEAR_UP, RND_AWAY: to_inf = 1'b1;
            RND_PINF:                        to_inf = !s1_sgn_q;
            RND_NINF:                        to_inf = s1_sgn_q;
            default:                         to_inf = 1'b0;
        endcase
        out_sgn_d      = s1_sgn_q;
        out_inexact_d  = s1_inexact_q | ovf;
        out_overflow_d = ovf;
        out_exp_d      = exp_n[EXP_W-1:0];
        out_mant_d     = mant_n;
        if (ovf && to_inf) begin
            out_exp_d  = '1;
            out_mant_d = '0;
        end else if (ovf) begin
            out_exp_d  = EXP_MAXF;
            out_mant_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sgn_q     <= 1'b0;
            s1_exp_q     <= '0;
            s1_sum_q     <= '0;
            s1_rnd_q     <= RND_NEAR;
            s1_inexact_q <= 1'b0;
        end else if (s1_load) begin
            s1_sgn_q     <= in_sgn;
            s1_exp_q     <= in_exp;
            s1_sum_q     <= s1_sum_d;
            s1_rnd_q     <= s1_rnd_d;
            s1_inexact_q <= s1_inexact_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sgn_q      <= 1'b0;
            out_exp_q      <= '0;
            out_mant_q     <= '0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else if (s2_load) begin
            out_sgn_q      <= out_sgn_d;
            out_exp_q      <= out_exp_d;
            out_mant_q     <= out_mant_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sgn      = out_sgn_q;
    assign out_exp      = out_exp_q;
    assign out_mant     = out_mant_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_round_norm_pipe.sv
// Directed-vector bench for round_norm_pipe (MANT_W=24, EXP_W=8).
// Expected results are hand-computed from the rounding and saturation rules.
module tb_round_norm_pipe;
    logic        clk, rst;
    logic        in_valid, in_ready, in_sgn, in_guard, in_sticky;
    logic [8:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_rnd;
    logic        out_valid, out_ready, out_sgn, out_inexact, out_overflow;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic [34:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        sgn;
        logic [8:0]  ie;
        logic [23:0] im;
        logic        g;
        logic        s;
        logic [2:0]  rnd;
        logic [7:0]  ee;
        logic [23:0] em;
        logic        ei;
        logic        eo;
    } vec_t;

    round_norm_pipe #(.MANT_W(24), .EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sgn(in_sgn), .in_exp(in_exp),
        .in_mant(in_mant), .in_guard(in_guard), .in_sticky(in_sticky), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_sgn(out_sgn), .out_exp(out_exp),
        .out_mant(out_mant), .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    assign obs = {out_sgn, out_exp, out_mant, out_inexact, out_overflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic sgn, logic [8:0] ie, logic [23:0] im, logic g, logic s,
                                logic [2:0] rnd, logic [7:0] ee, logic [23:0] em, logic ei, logic eo);
        vec_t v;
        v.sgn = sgn; v.ie = ie; v.im = im; v.g = g; v.s = s; v.rnd = rnd;
        v.ee = ee; v.em = em; v.ei = ei; v.eo = eo;
        return v;
    endfunction

    function automatic logic [34:0] want(vec_t v);
        return {v.sgn, v.ee, v.em, v.ei, v.eo};
    endfunction

    task automatic drive(vec_t v);
        in_sgn = v.sgn; in_exp = v.ie; in_mant = v.im;
        in_guard = v.g; in_sticky = v.s; in_rnd = v.rnd;
    endtask

    // Single isolated beat with out_ready high; lat counts negedges from the accepting edge.
    task automatic beat(input vec_t v, output logic [34:0] res, output int lat, output bit to);
        to = 1'b0; lat = 0; res = '0;
        @(negedge clk);
        drive(v); in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
        if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
        @(posedge clk); #1 in_valid = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) to = 1'b1;
        res = obs;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(1'b0, 9'h0, 24'h0, 1'b0, 1'b0, 3'd0, 8'h0, 24'h0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== 35'h0) begin
            n_err++; $display("FAIL reset_outputs: valid=%b data=%h, required valid=0 data=0", out_valid, obs);
        end
        rst = 1'b0; #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ties_even();
        vec_t q[$]; logic [34:0] res; int lat; bit to;
        q.push_back(mk(1'b0, 9'h080, 24'h800001, 1'b1, 1'b0, 3'd0, 8'h80, 24'h800002, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800002, 1'b1, 1'b0, 3'd0, 8'h80, 24'h800002, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h080, 24'h800002, 1'b1, 1'b1, 3'd0, 8'h80, 24'h800003, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800003, 1'b0, 1'b1, 3'd0, 8'h80, 24'h800003, 1'b1, 1'b0));
        foreach (q[i]) begin
            beat(q[i], res, lat, to);
            n_cmp++;
            if (to || res !== want(q[i])) begin
                n_err++; $display("FAIL ties_even[%0d]: got %h timeout=%0d, required %h", i, res, to, want(q[i]));
            end
        end
    endtask

    task automatic test_carry();
        vec_t v; logic [34:0] res; int lat; bit to;
        v = mk(1'b0, 9'h080, 24'hFFFFFF, 1'b1, 1'b1, 3'd0, 8'h81, 24'h800000, 1'b1, 1'b0);
        beat(v, res, lat, to);
        n_cmp++;
        if (to || res !== want(v)) begin
            n_err++; $display("FAIL carry_renorm: got %h timeout=%0d, required %h", res, to, want(v));
        end
        n_cmp++;
        if (lat != 2) begin
            n_err++; $display("FAIL carry_latency: got %0d cycles, required 2", lat);
        end
    endtask

    task automatic test_overflow();
        vec_t q[$]; logic [34:0] res; int lat; bit to;
        q.push_back(mk(1'b0, 9'h0FE, 24'hFFFFFF, 1'b1, 1'b0, 3'd0, 8'hFF, 24'h000000, 1'b1, 1'b1));
        q.push_back(mk(1'b0, 9'h0FE, 24'hFFFFFF, 1'b1, 1'b0, 3'd1, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h0FF, 24'h800000, 1'b0, 1'b0, 3'd1, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1));
        q.push_back(mk(1'b1, 9'h0FF, 24'hFFFFFF, 1'b1, 1'b0, 3'd2, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1));
        q.push_back(mk(1'b0, 9'h0FE, 24'hFFFFFF, 1'b1, 1'b0, 3'd2, 8'hFF, 24'h000000, 1'b1, 1'b1));
        q.push_back(mk(1'b1, 9'h0FE, 24'hFFFFFF, 1'b0, 1'b1, 3'd3, 8'hFF, 24'h000000, 1'b1, 1'b1));
        q.push_back(mk(1'b0, 9'h0FF, 24'h800000, 1'b0, 1'b0, 3'd3, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1));
        q.push_back(mk(1'b1, 9'h100, 24'h800000, 1'b0, 1'b0, 3'd0, 8'hFF, 24'h000000, 1'b1, 1'b1));
        q.push_back(mk(1'b0, 9'h0FF, 24'h800000, 1'b0, 1'b0, 3'd6, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1));
        q.push_back(mk(1'b1, 9'h0FD, 24'hFFFFFF, 1'b1, 1'b1, 3'd5, 8'hFE, 24'h800000, 1'b1, 1'b0));
        foreach (q[i]) begin
            beat(q[i], res, lat, to);
            n_cmp++;
            if (to || res !== want(q[i])) begin
                n_err++; $display("FAIL overflow[%0d]: got %h timeout=%0d, required %h", i, res, to, want(q[i]));
            end
        end
    endtask

    task automatic test_modes();
        vec_t q[$]; logic [34:0] res; int lat; bit to;
        q.push_back(mk(1'b1, 9'h080, 24'h800000, 1'b0, 1'b1, 3'd3, 8'h80, 24'h800001, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b0, 1'b1, 3'd3, 8'h80, 24'h800000, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b0, 1'b0, 3'd5, 8'h80, 24'h800000, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b0, 1'b1, 3'd5, 8'h80, 24'h800001, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b1, 1'b1, 3'd7, 8'h80, 24'h800000, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h080, 24'h800001, 1'b1, 1'b1, 3'd6, 8'h80, 24'h800001, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b1, 1'b0, 3'd4, 8'h80, 24'h800001, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h080, 24'h800000, 1'b0, 1'b1, 3'd2, 8'h80, 24'h800000, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b0, 1'b1, 3'd2, 8'h80, 24'h800001, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h080, 24'h800000, 1'b1, 1'b1, 3'd1, 8'h80, 24'h800000, 1'b1, 1'b0));
        foreach (q[i]) begin
            beat(q[i], res, lat, to);
            n_cmp++;
            if (to || res !== want(q[i])) begin
                n_err++; $display("FAIL modes[%0d]: got %h timeout=%0d, required %h", i, res, to, want(q[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$]; int sent = 0; int got = 0; int cyc = 0;
        q.push_back(mk(1'b0, 9'h050, 24'hC00010, 1'b1, 1'b1, 3'd0, 8'h50, 24'hC00011, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h050, 24'hC00021, 1'b0, 1'b1, 3'd0, 8'h50, 24'hC00021, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h050, 24'hC000FF, 1'b1, 1'b0, 3'd0, 8'h50, 24'hC00100, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h051, 24'hFFFFFE, 1'b1, 1'b0, 3'd0, 8'h51, 24'hFFFFFE, 1'b1, 1'b0));
        out_ready = 1'b1;
        for (cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 4);
            if (sent < 4) drive(q[sent]);
            #1;
            if (out_valid) begin
                n_cmp++;
                if (obs !== want(q[got])) begin
                    n_err++; $display("FAIL b2b_data[%0d]: got %h, required %h", got, obs, want(q[got]));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 4 || cyc != 6) begin
            n_err++; $display("FAIL b2b_throughput: got %0d beats in %0d cycles, required 4 in 6", got, cyc);
        end
    endtask

    task automatic test_backpressure();
        vec_t q[$]; logic [34:0] snap; bit have_snap = 1'b0;
        int sent = 0; int got = 0; int extra = 0;
        q.push_back(mk(1'b0, 9'h041, 24'hA00000, 1'b1, 1'b0, 3'd4, 8'h41, 24'hA00001, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h042, 24'hA00001, 1'b1, 1'b0, 3'd4, 8'h42, 24'hA00002, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h043, 24'hA00002, 1'b1, 1'b0, 3'd4, 8'h43, 24'hA00003, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 9'h044, 24'hA00003, 1'b1, 1'b0, 3'd4, 8'h44, 24'hA00004, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 9'h045, 24'hA00004, 1'b1, 1'b0, 3'd4, 8'h45, 24'hA00005, 1'b1, 1'b0));
        snap = '0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (sent < 5);
            if (sent < 5) drive(q[sent]);
            #1;
            if (cyc == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1) begin
                    n_err++; $display("FAIL bp_ready_fall: in_ready=%b held=%0d out_valid=%b, required 0/2/1", in_ready, sent, out_valid);
                end
            end
            if (out_valid && !out_ready) begin
                if (!have_snap) begin
                    snap = obs; have_snap = 1'b1;
                end else begin
                    n_cmp++;
                    if (obs !== snap) begin
                        n_err++; $display("FAIL bp_stall_stable: got %h, required %h", obs, snap);
                    end
                end
            end else if (out_valid) begin
                n_cmp++;
                if (obs !== want(q[got])) begin
                    n_err++; $display("FAIL bp_data[%0d]: got %h, required %h", got, obs, want(q[got]));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (out_valid) extra++;
        end
        n_cmp++;
        if (got != 5 || extra != 0) begin
            n_err++; $display("FAIL bp_count: got %0d beats plus %0d extra, required 5 plus 0", got, extra);
        end
    endtask

    task automatic test_reset_midstream();
        vec_t v; logic [34:0] res; int lat; bit to; int stale = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(mk(1'b1, 9'h060, 24'h900000, 1'b1, 1'b1, 3'd5, 8'h60, 24'h900001, 1'b1, 1'b0));
            in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_setup: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== 35'h0) begin
            n_err++; $display("FAIL rst_mid_async: out_valid=%b data=%h, required 0/0", out_valid, obs);
        end
        @(negedge clk); #2 rst = 1'b0; out_ready = 1'b1; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_ready: in_ready=%b, required 1", in_ready);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_err++; $display("FAIL rst_mid_stale: %0d stale beats, required 0", stale);
        end
        v = mk(1'b0, 9'h070, 24'hB00001, 1'b1, 1'b0, 3'd0, 8'h70, 24'hB00002, 1'b1, 1'b0);
        beat(v, res, lat, to);
        n_cmp++;
        if (to || res !== want(v)) begin
            n_err++; $display("FAIL rst_mid_recover: got %h timeout=%0d, required %h", res, to, want(v));
        end
    endtask

    initial begin
        test_reset();
        test_ties_even();
        test_carry();
        test_overflow();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
